// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide sequencer owning the HI/LO registers.
// Results are computed at issue and committed after a fixed latency.
module mdu_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] input1,
  input  logic [31:0] input2,
  input  logic [3:0]  option,
  input  logic        start,
  input  logic        req,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] result
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CW-1:0] MULT_M1 = CW'(MULT_LAT - 1);
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV_LAT - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t          state_r, state_nxt_s;
  logic            busy_r;
  logic [CW-1:0]   cnt_r;
  logic [31:0]     hi_r, lo_r, pend_hi_r, pend_lo_r;
  logic            pend_we_r;

  logic            accept_s, md_op_s;
  logic [31:0]     pend_hi_s, pend_lo_s;
  logic            pend_we_s;
  logic [CW-1:0]   lat_s;

  logic signed [63:0] smul_s;
  logic [63:0]     umul_s;
  logic            a_neg_s, b_neg_s;
  logic [31:0]     a_mag_s, b_mag_s, sq_mag_s, sr_mag_s, ub_s, uq_s, ur_s;

  assign accept_s = start & ~req & ~busy_r;
  assign md_op_s  = (option >= 4'd1) && (option <= 4'd4);

  // Arithmetic datapath; divisors of zero are forced to one so the dividers never see zero.
  assign smul_s   = $signed({{32{input1[31]}}, input1}) * $signed({{32{input2[31]}}, input2});
  assign umul_s   = {32'd0, input1} * {32'd0, input2};
  assign a_neg_s  = input1[31];
  assign b_neg_s  = input2[31];
  assign a_mag_s  = a_neg_s ? (32'd0 - input1) : input1;
  assign b_mag_s  = (input2 == 32'd0) ? 32'd1 : (b_neg_s ? (32'd0 - input2) : input2);
  assign sq_mag_s = a_mag_s / b_mag_s;
  assign sr_mag_s = a_mag_s % b_mag_s;
  assign ub_s     = (input2 == 32'd0) ? 32'd1 : input2;
  assign uq_s     = input1 / ub_s;
  assign ur_s     = input1 % ub_s;

  // Pending HI/LO, write enable and latency for the operation being offered.
  always_comb begin
    pend_hi_s = hi_r;
    pend_lo_s = lo_r;
    pend_we_s = 1'b0;
    lat_s     = {CW{1'b0}};
    case (option)
      4'd1: begin
        pend_hi_s = smul_s[63:32];
        pend_lo_s = smul_s[31:0];
        pend_we_s = 1'b1;
        lat_s     = MULT_M1;
      end
      4'd2: begin
        pend_hi_s = umul_s[63:32];
        pend_lo_s = umul_s[31:0];
        pend_we_s = 1'b1;
        lat_s     = MULT_M1;
      end
      4'd3: begin
        pend_lo_s = (a_neg_s ^ b_neg_s) ? (32'd0 - sq_mag_s) : sq_mag_s;
        pend_hi_s = a_neg_s ? (32'd0 - sr_mag_s) : sr_mag_s;
        pend_we_s = (input2 != 32'd0);
        lat_s     = DIV_M1;
      end
      4'd4: begin
        pend_lo_s = uq_s;
        pend_hi_s = ur_s;
        pend_we_s = (input2 != 32'd0);
        lat_s     = DIV_M1;
      end
      default: pend_we_s = 1'b0;
    endcase
  end

  // FSM state register; busy mirrors the RUN state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == RUN);
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && md_op_s) state_nxt_s = RUN;
        else                     state_nxt_s = IDLE;
      end
      RUN: begin
        if (cnt_r == {CW{1'b0}}) state_nxt_s = IDLE;
        else                     state_nxt_s = RUN;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Counter, pending capture and HI/LO updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r     <= {CW{1'b0}};
      pend_hi_r <= 32'd0;
      pend_lo_r <= 32'd0;
      pend_we_r <= 1'b0;
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            case (option)
              4'd1, 4'd2, 4'd3, 4'd4: begin
                pend_hi_r <= pend_hi_s;
                pend_lo_r <= pend_lo_s;
                pend_we_r <= pend_we_s;
                cnt_r     <= lat_s;
              end
              4'd5:    hi_r <= input1;
              4'd6:    lo_r <= input1;
              default: cnt_r <= cnt_r;
            endcase
          end else begin
            cnt_r <= cnt_r;
          end
        end
        RUN: begin
          if (cnt_r == {CW{1'b0}}) begin
            if (pend_we_r) begin
              hi_r <= pend_hi_r;
              lo_r <= pend_lo_r;
            end else begin
              hi_r <= hi_r;
            end
          end else begin
            cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
          end
        end
        default: cnt_r <= {CW{1'b0}};
      endcase
    end
  end

  // mfhi/mflo read port.
  always_comb begin
    result = 32'd0;
    case (option)
      4'd7:    result = hi_r;
      4'd8:    result = lo_r;
      default: result = 32'd0;
    endcase
  end

  assign busy = busy_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: latency, arithmetic, mt/mf, busy-ignore, req and reset.
module tb_mdu_ctrl;

  logic        clk, reset, start, req, busy;
  logic [31:0] input1, input2, hi, lo, result;
  logic [3:0]  option;
  int          total = 0;
  int          bad   = 0;

  mdu_ctrl #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .reset(reset), .input1(input1), .input2(input2), .option(option),
    .start(start), .req(req), .busy(busy), .hi(hi), .lo(lo), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one instruction for a single cycle; returns 1ns after the issue edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; option = op; input1 = a; input2 = b; req = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; option = 4'd0;
  endtask

  // Counts busy cycles until busy drops (bounded); ends at the negedge of the first idle cycle.
  task automatic wait_idle(input string tag, input int lat);
    int n;
    n = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (busy) n++;
      else break;
    end
    chk(tag, 32'(n), 32'(lat));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; req = 1'b0; option = 4'd0;
    input1 = 32'd0; input2 = 32'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_result", result, 32'd0);

    issue(4'd1, 32'hFFFFFFFD, 32'd5);
    wait_idle("mult_lat", 5);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFF1);

    issue(4'd2, 32'hFFFFFFFD, 32'd5);
    wait_idle("multu_lat", 5);
    chk("multu_hi", hi, 32'h00000004);
    chk("multu_lo", lo, 32'hFFFFFFF1);

    issue(4'd3, 32'hFFFFFFF9, 32'd2);
    wait_idle("div_lat", 10);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);

    issue(4'd4, 32'd7, 32'd2);
    wait_idle("divu_lat", 10);
    chk("divu_lo", lo, 32'd3);
    chk("divu_hi", hi, 32'd1);

    issue(4'd3, 32'h80000000, 32'hFFFFFFFF);
    wait_idle("divovf_lat", 10);
    chk("divovf_lo", lo, 32'h80000000);
    chk("divovf_hi", hi, 32'd0);

    issue(4'd5, 32'h1234, 32'd0);
    chk("mthi_nobusy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("mthi_hi", hi, 32'h1234);
    issue(4'd6, 32'h5678, 32'd0);
    @(negedge clk);
    chk("mtlo_lo", lo, 32'h5678);
    issue(4'd4, 32'd9, 32'd0);
    wait_idle("divz_lat", 10);
    chk("divz_hi", hi, 32'h1234);
    chk("divz_lo", lo, 32'h5678);
    option = 4'd7; #1;
    chk("mfhi", result, 32'h1234);
    option = 4'd8; #1;
    chk("mflo", result, 32'h5678);
    option = 4'd0;

    // req blocks issue of mult and mthi
    @(negedge clk);
    start = 1'b1; option = 4'd1; req = 1'b1; input1 = 32'd2; input2 = 32'd3;
    @(posedge clk); #1 option = 4'd5; input1 = 32'hBEEF;
    @(posedge clk); #1 start = 1'b0; req = 1'b0; option = 4'd0;
    @(negedge clk);
    chk("req_busy", {31'd0, busy}, 32'd0);
    chk("req_hi", hi, 32'h1234);
    chk("req_lo", lo, 32'h5678);

    issue(4'd12, 32'hDEAD, 32'd1);
    @(negedge clk);
    chk("opt12_busy", {31'd0, busy}, 32'd0);
    chk("opt12_hi", hi, 32'h1234);

    // requests presented while busy are dropped
    issue(4'd1, 32'd3, 32'd4);
    start = 1'b1; option = 4'd4; input1 = 32'd100; input2 = 32'd7;
    @(posedge clk); #1 option = 4'd5; input1 = 32'hAAAA;
    @(posedge clk); #1 start = 1'b0; option = 4'd0;
    wait_idle("ign_lat", 3);
    chk("ign_hi", hi, 32'd0);
    chk("ign_lo", lo, 32'd12);
    issue(4'd1, 32'h00010000, 32'h00010000);
    wait_idle("b2b_lat", 5);
    chk("b2b_hi", hi, 32'd1);
    chk("b2b_lo", lo, 32'd0);

    // req pulse mid-run does not abort
    issue(4'd3, 32'd100, 32'hFFFFFFF9);
    @(posedge clk); #1 req = 1'b1;
    @(posedge clk); #1 req = 1'b0;
    wait_idle("reqrun_lat", 8);
    chk("reqrun_lo", lo, 32'hFFFFFFF2);
    chk("reqrun_hi", hi, 32'd2);

    // reset in cycle 3 of a div
    issue(4'd3, 32'hFFFFFFF9, 32'd2);
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_hi", hi, 32'd0);
    chk("mrst_lo", lo, 32'd0);
    repeat (15) @(negedge clk);
    chk("mrst_late_hi", hi, 32'd0);
    chk("mrst_late_lo", lo, 32'd0);
    chk("mrst_late_busy", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
